axi4_mmio_slave: RTL

AXI4_MMIO_SLAVE -- requirements
Module: axi4_mmio_slave

---
 rtl/axi4_mmio_slave.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_mmio_slave.sv
// axi4_mmio_slave: AXI4 slave with LED/PEND/EN/SCRATCH registers decoded in a 4 KB window.
// Latency: B one cycle after the final W beat; each R beat registered one cycle after its AR/R handshake.
// Backpressure: one burst per channel at a time; bvalid/rvalid and their payloads hold until ready.
module axi4_mmio_slave #(
  parameter int ID_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            S_AXI_awvalid,
  output logic            S_AXI_awready,
  input  logic [ID_W-1:0] S_AXI_awid,
  input  logic [31:0]     S_AXI_awaddr,
  input  logic [7:0]      S_AXI_awlen,
  input  logic [2:0]      S_AXI_awsize,
  input  logic [1:0]      S_AXI_awburst,
  input  logic            S_AXI_wvalid,
  output logic            S_AXI_wready,
  input  logic [63:0]     S_AXI_wdata,
  input  logic [7:0]      S_AXI_wstrb,
  input  logic            S_AXI_wlast,
  output logic            S_AXI_bvalid,
  input  logic            S_AXI_bready,
  output logic [ID_W-1:0] S_AXI_bid,
  output logic [1:0]      S_AXI_bresp,
  input  logic            S_AXI_arvalid,
  output logic            S_AXI_arready,
  input  logic [ID_W-1:0] S_AXI_arid,
  input  logic [31:0]     S_AXI_araddr,
  input  logic [7:0]      S_AXI_arlen,
  input  logic [2:0]      S_AXI_arsize,
  input  logic [1:0]      S_AXI_arburst,
  output logic            S_AXI_rvalid,
  input  logic            S_AXI_rready,
  output logic [ID_W-1:0] S_AXI_rid,
  output logic [63:0]     S_AXI_rdata,
  output logic [1:0]      S_AXI_rresp,
  output logic            S_AXI_rlast,
  input  logic [5:0]      irq_src,
  output logic [7:0]      led,
  output logic [5:0]      ext_intrs
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [8:0] IDX_LED     = 9'd0;
  localparam logic [8:0] IDX_PEND    = 9'd1;
  localparam logic [8:0] IDX_EN      = 9'd2;
  localparam logic [8:0] IDX_SCRATCH = 9'd3;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  // register file
  logic [7:0]  led_q;
  logic [5:0]  pend_q;
  logic [5:0]  en_q;
  logic [5:0]  irq_q;
  logic [63:0] scratch_q;

  // write burst context; only addr[11:3] matters, so the beat address is a 9-bit word index
  logic [ID_W-1:0] w_id;
  logic [8:0]      w_idx;
  logic [7:0]      w_len;
  logic [7:0]      w_cnt;
  logic            w_incr;
  logic            w_discard;
  logic            w_err;

  // read burst context
  logic [ID_W-1:0] r_id;
  logic [8:0]      r_idx;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;
  logic            r_incr;
  logic            r_discard;
  logic [63:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic            rlast_q;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        aw_bad, ar_bad;
  logic        w_final, w_unmapped;
  logic [5:0]  pend_clr, pend_nxt;
  logic [8:0]  rd_idx;
  logic        rd_discard;
  logic [63:0] rd_data;
  logic        rd_err;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_awaddr[31:12], S_AXI_awaddr[2:0],
                              S_AXI_araddr[31:12], S_AXI_araddr[2:0]};

  // WRAP, the reserved burst type and transfers wider than the 64-bit bus are swallowed with SLVERR
  function automatic logic bad_burst(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size > 3'd3);
  endfunction

  assign aw_bad = bad_burst(S_AXI_awburst, S_AXI_awsize);
  assign ar_bad = bad_burst(S_AXI_arburst, S_AXI_arsize);

  // handshakes are derived from state so they never loop back through the ready outputs
  assign aw_hs = S_AXI_awvalid && reset && (w_state == W_IDLE);
  assign w_hs  = S_AXI_wvalid  && reset && (w_state == W_DATA);
  assign b_hs  = S_AXI_bready  && reset && (w_state == W_RESP);
  assign ar_hs = S_AXI_arvalid && reset && (r_state == R_IDLE);
  assign r_hs  = S_AXI_rready  && reset && (r_state == R_DATA);

  // termination is by beat count only; wlast is merely cross-checked
  assign w_final    = (w_cnt == w_len);
  assign w_unmapped = (w_idx > IDX_SCRATCH);

  // state registers for both channel FSMs
  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // write FSM next state and ready/valid outputs
  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_awready = 1'b0;
    S_AXI_wready  = 1'b0;
    S_AXI_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_awready = reset;
        if (aw_hs) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        S_AXI_wready = reset;
        if (w_hs && w_final) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_bvalid = reset;
        if (b_hs) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // capture the write burst on AW, then step beat count/address and accumulate errors per beat
  always_ff @(posedge clock) begin
    if (!reset) begin
      w_id      <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_incr    <= 1'b0;
      w_discard <= 1'b0;
      w_err     <= 1'b0;
    end else if (aw_hs) begin
      w_id      <= S_AXI_awid;
      w_idx     <= S_AXI_awaddr[11:3];
      w_len     <= S_AXI_awlen;
      w_cnt     <= '0;
      w_incr    <= (S_AXI_awburst == BURST_INCR);
      w_discard <= aw_bad;
      w_err     <= aw_bad;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (w_incr) w_idx <= w_idx + 9'd1;
      if ((S_AXI_wlast != w_final) || (!w_discard && w_unmapped)) w_err <= 1'b1;
    end
  end

  // W1C mask for this cycle; a new irq edge overrides a coincident clear
  always_comb begin
    pend_clr = '0;
    if (w_hs && !w_discard && (w_idx == IDX_PEND) && S_AXI_wstrb[0]) pend_clr = S_AXI_wdata[5:0];
    pend_nxt = (pend_q & ~pend_clr) | (irq_src & ~irq_q);
  end

  // register file updates: irq edge history, pending bits and byte-enabled writes
  always_ff @(posedge clock) begin
    if (!reset) begin
      led_q     <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      irq_q     <= '0;
      scratch_q <= '0;
    end else begin
      irq_q  <= irq_src;
      pend_q <= pend_nxt;
      if (w_hs && !w_discard) begin
        case (w_idx)
          IDX_LED: if (S_AXI_wstrb[0]) led_q <= S_AXI_wdata[7:0];
          IDX_EN:  if (S_AXI_wstrb[0]) en_q <= S_AXI_wdata[5:0];
          IDX_SCRATCH: begin
            for (int i = 0; i < 8; i++) begin
              if (S_AXI_wstrb[i]) scratch_q[8*i +: 8] <= S_AXI_wdata[8*i +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // read FSM next state and ready/valid outputs
  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_arready = 1'b0;
    S_AXI_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_arready = reset;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        S_AXI_rvalid = reset;
        if (r_hs && rlast_q) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // look up the beat to be registered next: the AR address when idle, else the following beat
  always_comb begin
    if (r_state == R_IDLE) begin
      rd_idx     = S_AXI_araddr[11:3];
      rd_discard = ar_bad;
    end else begin
      rd_idx     = r_incr ? (r_idx + 9'd1) : r_idx;
      rd_discard = r_discard;
    end
    rd_data = '0;
    rd_err  = rd_discard;
    if (!rd_discard) begin
      case (rd_idx)
        IDX_LED:     rd_data = {56'd0, led_q};
        IDX_PEND:    rd_data = {58'd0, pend_q};
        IDX_EN:      rd_data = {58'd0, en_q};
        IDX_SCRATCH: rd_data = scratch_q;
        default:     rd_err  = 1'b1;
      endcase
    end
  end

  // capture the read burst and register each beat; payload only moves on a handshake
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_id      <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_incr    <= 1'b0;
      r_discard <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else if (ar_hs) begin
      r_id      <= S_AXI_arid;
      r_idx     <= rd_idx;
      r_len     <= S_AXI_arlen;
      r_cnt     <= '0;
      r_incr    <= (S_AXI_arburst == BURST_INCR);
      r_discard <= ar_bad;
      rdata_q   <= rd_data;
      rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
      rlast_q   <= (S_AXI_arlen == 8'd0);
    end else if (r_hs && !rlast_q) begin
      r_idx   <= rd_idx;
      r_cnt   <= r_cnt + 8'd1;
      rdata_q <= rd_data;
      rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      rlast_q <= ((r_cnt + 8'd1) == r_len);
    end
  end

  assign S_AXI_bid   = w_id;
  assign S_AXI_bresp = w_err ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_rid   = r_id;
  assign S_AXI_rdata = rdata_q;
  assign S_AXI_rresp = rresp_q;
  assign S_AXI_rlast = S_AXI_rvalid && rlast_q;
  assign led         = reset ? led_q : 8'd0;
  assign ext_intrs   = reset ? (pend_q & en_q) : 6'd0;

endmodule
